// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war round controller.
// Holds the FSM state encoding and the LFSR polynomial and seed.
package tow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LIT,
        ST_REPORT,
        ST_HOLD
    } state_t;

    localparam int LFSR_W = 8;

    // x^8 + x^6 + x^5 + x^4 + 1 taps the register at bits 7, 5, 4 and 3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/round_ctl_if.sv
// Button, timebase and result signals between the game board and round_ctl.
// The master drives buttons and tick; the slave (round_ctl) drives the result.
interface round_ctl_if;
    logic tick;
    logic pbl;
    logic pbr;
    logic winrnd;
    logic right;
    logic tie;
    logic leds_on;

    modport master (output tick, pbl, pbr, input winrnd, right, tie, leds_on);
    modport slave  (input tick, pbl, pbr, output winrnd, right, tie, leds_on);
endinterface

// File: rtl/pb_sync.sv
// Two-flop synchroniser for one asynchronous push-button.
module pb_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make both flops sample together, forming a real two-stage chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/round_ctl.sv
// Round controller: random lights-off delay, first-push arbitration and the
// registered one-cycle result pulse consumed by the scorer.
module round_ctl
    import tow_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int RAND_W      = 8,
    parameter int MIN_WAIT    = 500,
    parameter int LIT_TIMEOUT = 2000
) (
    input  logic        clk,
    input  logic        rst,
    round_ctl_if.slave  io_rnd
);

    if (MIN_WAIT + (1 << RAND_W) - 1 >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("round_ctl: MIN_WAIT + 2**RAND_W - 1 does not fit in CNT_W bits");
    end
    if (LIT_TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
        $error("round_ctl: LIT_TIMEOUT does not fit in CNT_W bits");
    end
    if (RAND_W > LFSR_W) begin : g_bad_rand_w
        $error("round_ctl: RAND_W exceeds the LFSR width");
    end

    localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] LIT_C      = CNT_W'(LIT_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    logic              w_sl;
    logic              w_sr;
    logic              w_push;
    logic [CNT_W-1:0]  w_rand;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LFSR_W-1:0] r_lfsr;
    logic              r_winrnd;
    logic              r_right;
    logic              r_tie;
    logic              r_leds_on;

    state_t            w_state_n;
    logic [CNT_W-1:0]  w_cnt_n;
    logic              w_winrnd_n;
    logic              w_right_n;
    logic              w_tie_n;
    logic              w_leds_n;

    pb_sync u_sync_l (.clk(clk), .rst(rst), .i_async(io_rnd.pbl), .o_sync(w_sl));
    pb_sync u_sync_r (.clk(clk), .rst(rst), .i_async(io_rnd.pbr), .o_sync(w_sr));

    assign w_push = w_sl | w_sr;
    assign w_rand = CNT_W'(r_lfsr[RAND_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_lfsr  <= lfsr_next(r_lfsr);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;

        // A push is tested before tick so it wins over a simultaneous expiry.
        case (r_state)
            ST_IDLE: begin
                if (!w_push) begin
                    w_cnt_n   = MIN_WAIT_C + w_rand;
                    w_state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_push) begin
                    w_state_n = ST_REPORT;
                end else if (io_rnd.tick) begin
                    if (r_cnt == '0) begin
                        w_cnt_n   = LIT_C;
                        w_state_n = ST_LIT;
                    end else begin
                        w_cnt_n = r_cnt - ONE_C;
                    end
                end
            end
            ST_LIT: begin
                if (w_push) begin
                    w_state_n = ST_REPORT;
                end else if (io_rnd.tick) begin
                    if (r_cnt == '0) begin
                        w_state_n = ST_IDLE;
                    end else begin
                        w_cnt_n = r_cnt - ONE_C;
                    end
                end
            end
            ST_REPORT: w_state_n = ST_HOLD;
            ST_HOLD: begin
                if (!w_push) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // Outputs are computed from the next state so they can be registered.
        w_winrnd_n = (w_state_n == ST_REPORT);
        w_right_n  = w_winrnd_n & w_sr & ~w_sl;
        w_tie_n    = w_winrnd_n & w_sl & w_sr;
        w_leds_n   = (w_state_n == ST_LIT) | (w_winrnd_n & (r_state == ST_LIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_winrnd  <= 1'b0;
            r_right   <= 1'b0;
            r_tie     <= 1'b0;
            r_leds_on <= 1'b0;
        end else begin
            r_winrnd  <= w_winrnd_n;
            r_right   <= w_right_n;
            r_tie     <= w_tie_n;
            r_leds_on <= w_leds_n;
        end
    end

    assign io_rnd.winrnd  = r_winrnd;
    assign io_rnd.right   = r_right;
    assign io_rnd.tie     = r_tie;
    assign io_rnd.leds_on = r_leds_on;

endmodule

// File: tb/tb_round_ctl.sv
// Self-checking bench for round_ctl: directed scenarios followed by random
// button bursts, compared every cycle against a timestamp-based round model.
module tb_round_ctl;

    localparam int MIN_WAIT    = 4;
    localparam int LIT_TIMEOUT = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;

    round_ctl_if bus ();

    round_ctl #(
        .CNT_W      (16),
        .RAND_W     (8),
        .MIN_WAIT   (MIN_WAIT),
        .LIT_TIMEOUT(LIT_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_rnd(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: rounds described by the edge numbers at which the
    // lights come on and at which an unanswered round is abandoned.
    int         m_edge;
    bit         raw_l_q[$];
    bit         raw_r_q[$];
    logic [7:0] m_lfsr;
    bit         m_live;
    bit         m_hold;
    int         m_lit_edge;
    int         m_end_edge;
    int         m_report_edge;
    bit         e_win, e_right, e_tie, e_leds;
    int         cnt_win;
    int         cnt_leds;

    // Fibonacci shift of x^8 + x^6 + x^5 + x^4 + 1.
    function automatic logic [7:0] poly_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic model_reset();
        raw_l_q.delete();
        raw_r_q.delete();
        m_edge = 0;
        m_lfsr = 8'h01;
        m_live = 1'b0;
        m_hold = 1'b0;
        e_win = 1'b0; e_right = 1'b0; e_tie = 1'b0; e_leds = 1'b0;
    endtask

    task automatic model_edge(input bit raw_l, input bit raw_r);
        bit l, r;
        // The controller sees a button two edges after it was sampled.
        l = (raw_l_q.size() >= 2) ? raw_l_q[raw_l_q.size()-2] : 1'b0;
        r = (raw_r_q.size() >= 2) ? raw_r_q[raw_r_q.size()-2] : 1'b0;
        raw_l_q.push_back(raw_l);
        raw_r_q.push_back(raw_r);
        if (raw_l_q.size() > 2) void'(raw_l_q.pop_front());
        if (raw_r_q.size() > 2) void'(raw_r_q.pop_front());
        m_edge++;
        e_win = 1'b0; e_right = 1'b0; e_tie = 1'b0; e_leds = 1'b0;
        if (m_live) begin
            if (l | r) begin
                e_win   = 1'b1;
                e_right = r & ~l;
                e_tie   = l & r;
                e_leds  = (m_edge > m_lit_edge);
                m_live  = 1'b0;
                m_hold  = 1'b1;
                m_report_edge = m_edge;
            end else if (m_edge == m_end_edge) begin
                m_live = 1'b0;
            end else begin
                e_leds = (m_edge >= m_lit_edge);
            end
        end else if (m_hold) begin
            if (m_edge > m_report_edge + 1 && !l && !r) m_hold = 1'b0;
        end else if (!l && !r) begin
            m_live     = 1'b1;
            m_lit_edge = m_edge + MIN_WAIT + int'(m_lfsr) + 1;
            m_end_edge = m_lit_edge + LIT_TIMEOUT + 1;
        end
        m_lfsr = poly_step(m_lfsr);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d: observed=%0h expected=%0h", tag, m_edge, obs, exp);
        end
    endtask

    task automatic step(input bit l, input bit r);
        bus.pbl = l;
        bus.pbr = r;
        @(posedge clk);
        model_edge(l, r);
        #1;
        check("winrnd",  bus.winrnd,  e_win);
        check("right",   bus.right,   e_right);
        check("tie",     bus.tie,     e_tie);
        check("leds_on", bus.leds_on, e_leds);
        cnt_win  += int'(bus.winrnd);
        cnt_leds += int'(bus.leds_on);
    endtask

    task automatic do_reset();
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_winrnd",  bus.winrnd,  1'b0);
        check("rst_right",   bus.right,   1'b0);
        check("rst_tie",     bus.tie,     1'b0);
        check("rst_leds_on", bus.leds_on, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_until_lit(input string tag);
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b0);
            n++;
        end while (!e_leds && n < 400);
        check(tag, bus.leds_on, 1'b1);
    endtask

    task automatic run_until_live(input string tag);
        int n;
        n = 0;
        while (!m_live && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        check(tag, bus.leds_on, 1'b0);
    endtask

    initial begin
        bus.tick = 1'b1;
        bus.pbl  = 1'b0;
        bus.pbr  = 1'b0;
        #2;
        do_reset();

        // Proper right win, one pulse for a short press.
        run_until_lit("lit_right");
        cnt_win = 0;
        repeat (4) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("right_pulses", cnt_win, 1);

        // Left jumps the light: result with LEDs never lit.
        run_until_live("live_jump");
        cnt_leds = 0;
        cnt_win  = 0;
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        check("jump_pulses", cnt_win, 1);
        check("jump_dark", cnt_leds, 0);

        // Both players on the same edge while lit.
        run_until_lit("lit_tie");
        cnt_win = 0;
        repeat (3) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("tie_pulses", cnt_win, 1);

        // Long hold gives exactly one result.
        run_until_lit("lit_hold");
        cnt_win = 0;
        repeat (50) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("hold_pulses", cnt_win, 1);

        // Unanswered round: LEDs lit for LIT_TIMEOUT+1 cycles, no result.
        run_until_lit("lit_timeout");
        cnt_leds = 1;
        cnt_win  = 0;
        repeat (10) step(1'b0, 1'b0);
        check("timeout_lit_cycles", cnt_leds, LIT_TIMEOUT + 1);
        check("timeout_pulses", cnt_win, 0);

        // Reset while lit; the next round's timing reflects the reseeded LFSR.
        run_until_lit("lit_reset");
        repeat (2) step(1'b0, 1'b0);
        do_reset();
        cnt_win = 0;
        run_until_lit("lit_after_reset");
        check("reset_no_pulse", cnt_win, 0);

        // Random bursts of presses and releases.
        for (int b = 0; b < 80; b++) begin
            int p;
            int len;
            p = int'($urandom_range(0, 5));
            if (p <= 2) begin
                len = int'($urandom_range(1, 30));
                repeat (len) step(1'b0, 1'b0);
            end else begin
                len = int'($urandom_range(1, 6));
                repeat (len) step(p != 4, p != 3);
            end
        end
        repeat (5) step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_ctl.md
# round_ctl

Round controller for the tug-of-war game, directly upstream of the scorer. It synchronises the two player push-buttons and times a pseudo-random lights-off delay before turning the LEDs on. It decides who pushed first, or whether both pushed together, and issues the one-cycle `winrnd` pulse together with `right`, `tie` and `leds_on`, which the scorer consumes in the same cycle.

## Interface
Parameters:
- `CNT_W`, 16: width of the delay/timeout counter.
- `RAND_W`, 8: LFSR width; the random part of the delay is `lfsr[RAND_W-1:0]`.
- `MIN_WAIT`, 500: minimum lights-off wait, in ticks.
- `LIT_TIMEOUT`, 2000: ticks the LEDs stay on with no push before the round is abandoned.

Ports (one clock; reset is asynchronous and active-high; ports named `clk` and `rst`):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `tick`  in  1  one-cycle timebase enable from the prescaler (nominally 1 ms).
- `pbl`  in  1  left push-button, asynchronous, active-high.
- `pbr`  in  1  right push-button, asynchronous, active-high.
- `winrnd`  out  1  one-cycle pulse: a round result is valid.
- `right`  out  1  right player pushed first; valid while `winrnd`=1.
- `tie`  out  1  both players pushed in the same cycle; valid while `winrnd`=1.
- `leds_on`  out  1  LEDs lit. Its value during the `winrnd` cycle says whether the push was proper (1) or jumped the light (0).

## Operation
- **Synchronisation:** each button passes through a two-flop synchroniser. The FSM sees only the synchronised `sl` and `sr`.
- **LFSR:** 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Seed 8'h01 on reset. It advances every `clk`, not every `tick`, so its value depends on human timing.
- **IDLE:** `leds_on`=0. Stay while `sl|sr`. When both are released, load `cnt = MIN_WAIT + lfsr` (zero-extended to CNT_W) and go to WAIT.
- **WAIT:** `leds_on`=0. If `sl|sr`, go to REPORT with `lit_q`=0 (jump-the-light). Otherwise, on `tick`, decrement `cnt`. On `tick` with `cnt`==0, load `cnt=LIT_TIMEOUT` and go to LIT.
- **LIT:** `leds_on`=1. If `sl|sr`, go to REPORT with `lit_q`=1. Otherwise, on `tick`, decrement `cnt`. On `tick` with `cnt`==0, go to IDLE with no `winrnd` (round abandoned).
- **REPORT (one cycle):**
  - `winrnd`=1.
  - `right` = `sr & ~sl`.
  - `tie` = `sl & sr`.
  - `leds_on` = `lit_q`.
  - Next state is HOLD unconditionally.
  - `right` and `tie` are captured from `sl`/`sr` on the cycle of the transition into REPORT.
- **HOLD:** `leds_on`=0, `winrnd`=0. Go to IDLE when `~sl & ~sr`. This guarantees one result per press.
- **Push precedence:** a push takes priority over a simultaneous `tick` expiry in both WAIT and LIT.
- **Tie on a jump:** both players jumping in the same cycle gives `tie`=1 and `leds_on`=0. The scorer ignores it.
- **Output qualification:** `right` and `tie` are 0 in every state except REPORT.
- **Counter arithmetic:** `MIN_WAIT + 2^RAND_W - 1` must fit in CNT_W bits. Checked by a compile-time assertion. The counter never wraps because decrement is gated by `cnt != 0`.

## Timing
- **Reset values:** `winrnd`=0, `right`=0, `tie`=0, `leds_on`=0, state IDLE, synchronisers 0, LFSR 8'h01, `cnt`=0.
- **Reset mid-round:** all outputs drop to 0 asynchronously. The round is discarded with no `winrnd`.
- **All outputs are registered.**
- **Push latency:** a button first sampled high at edge k gives:
  - `sl`/`sr` high after edge k+1;
  - REPORT entered at edge k+2;
  - `winrnd` high for exactly the cycle between edges k+2 and k+3.
- **`leds_on` on a proper push:** rises on the edge entering LIT. It stays 1 through the REPORT cycle after a proper push and falls on the edge entering HOLD.
- **Minimum round length:** from release to LEDs on is `MIN_WAIT + lfsr + 1` ticks.

## Structure
- **Package `tow_pkg`:** state enum (IDLE, WAIT, LIT, REPORT, HOLD), LFSR tap constant, LFSR seed.
- **Sub-module `pb_sync`:** a two-flop synchroniser with async reset, instantiated once per button.
- **Top-level contents:** FSM, counter and LFSR live in `round_ctl`.

## Test plan
All runs use `MIN_WAIT`=4, `LIT_TIMEOUT`=6, `tick`=1 every cycle.

1. **Proper right win:** reset; wait for `leds_on`=1; raise `pbr` -> `winrnd` pulses 3 edges later with `right`=1, `tie`=0, `leds_on`=1; `leds_on`=0 on the next cycle.
2. **Jump the light:** raise `pbl` during WAIT -> `winrnd`=1 with `right`=0, `tie`=0, `leds_on`=0; the LEDs never light.
3. **Tie:** raise `pbl` and `pbr` on the same edge during LIT -> `winrnd`=1 with `tie`=1, `right`=0, `leds_on`=1.
4. **Hold/release:** keep `pbr` held for 50 cycles after a result -> exactly one `winrnd`; WAIT is re-entered only after release.
5. **Timeout:** no pushes -> `leds_on` is high for 7 cycles, then returns to 0 with no `winrnd`, and a new WAIT starts.
6. **Reset during LIT:** assert `rst` for 1 cycle -> `leds_on`=0 immediately; no `winrnd`; the LFSR restarts at 8'h01.
